// File: rtl/ahb_fill_master.sv
// ahb_fill_master
//
// AHB-Lite master that writes a block of consecutive 32-bit words.
// A command (base address, word count, fill value, increment flag) is taken
// from the local port while idle. The block then issues pipelined SINGLE
// NONSEQ writes and pulses done once the last data phase has completed.
//
// Ports
//   HCLK, HRESET         clock, synchronous active-high reset
//   start                command strobe, honoured only in IDLE
//   base_addr            byte address of first word (bits [1:0] ignored)
//   word_count           number of words, 0 completes immediately
//   fill_data, data_inc  first data word; data_inc=1 adds the beat index
//   busy, done, err      status: in progress, one-cycle completion, sticky error
//   HADDR..HWDATA        AHB-Lite master outputs (all registered)
//   HREADY, HRESP        AHB-Lite transfer-done and response inputs
module ahb_fill_master #(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      fill_data,
  input  logic             data_inc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAST,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic [31:0]      haddr_reg;
  logic [31:0]      hwdata_reg;
  logic [31:0]      beat_data_reg;  // data for the beat whose address is on the bus
  logic [CNT_W-1:0] remain_reg;     // address phases not yet accepted
  logic             nonseq_reg;     // 1: HTRANS=NONSEQ and HWRITE=1
  logic             inc_reg;
  logic             dphase_reg;     // a data phase is in progress this cycle
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;

  assign HADDR     = haddr_reg;
  assign HTRANS    = nonseq_reg ? 2'b10 : 2'b00;
  assign HWRITE    = nonseq_reg;
  assign HWDATA    = hwdata_reg;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg     <= S_IDLE;
      haddr_reg     <= 32'd0;
      hwdata_reg    <= 32'd0;
      beat_data_reg <= 32'd0;
      remain_reg    <= '0;
      nonseq_reg    <= 1'b0;
      inc_reg       <= 1'b0;
      dphase_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      // Any ERROR cycle of a data phase makes err stick until the next command.
      if (dphase_reg && HRESP) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            err_reg <= 1'b0;
            if (word_count == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg     <= S_RUN;
              haddr_reg     <= {base_addr[31:2], 2'b00};
              remain_reg    <= word_count;
              beat_data_reg <= fill_data;
              inc_reg       <= data_inc;
              nonseq_reg    <= 1'b1;
              dphase_reg    <= 1'b0;
              busy_reg      <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (HREADY) begin
            if (nonseq_reg) begin
              // Address phase accepted: its data phase starts next cycle.
              haddr_reg     <= haddr_reg + 32'd4;
              hwdata_reg    <= beat_data_reg;
              beat_data_reg <= beat_data_reg + {31'd0, inc_reg};
              remain_reg    <= remain_reg - CNT_ONE;
              dphase_reg    <= 1'b1;
              if (remain_reg == CNT_ONE) begin
                state_reg  <= S_LAST;
                nonseq_reg <= 1'b0;
              end
            end else begin
              // Second cycle of an ERROR response: the IDLE slot completes,
              // the dropped address is re-issued unchanged.
              nonseq_reg <= 1'b1;
              dphase_reg <= 1'b0;
            end
          end else if (HRESP && dphase_reg && nonseq_reg) begin
            // First ERROR cycle: withdraw the pending address phase.
            nonseq_reg <= 1'b0;
          end
        end

        S_LAST: begin
          if (HREADY) begin
            state_reg  <= S_DONE;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            dphase_reg <= 1'b0;
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_fill_master.sv
`timescale 1ns/1ps
// Directed bench for ahb_fill_master. A small AHB monitor records each
// completed data phase (address, data) while a per-cycle schedule drives
// HREADY/HRESP. Cycle 1 is the cycle after the edge that samples start.
module tb_ahb_fill_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [15:0] word_count = 16'd0;
  logic [31:0] fill_data = 32'd0;
  logic        data_inc = 1'b0;
  logic        busy, done, err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  ahb_fill_master #(.CNT_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .base_addr(base_addr),
    .word_count(word_count), .fill_data(fill_data), .data_inc(data_inc),
    .busy(busy), .done(done), .err(err), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;

  logic [1:0]  obs_trans [64];
  logic [31:0] obs_addr  [64];
  logic [31:0] obs_data  [64];
  logic        obs_busy  [64];
  logic        obs_err   [64];
  logic        obs_hwrite[64];
  int          done_cycle, done_count, busy_cycles, nonseq_cycles;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command and run the bus for ncyc-1 cycles. wait_mask/resp_mask
  // bit c gives HREADY=0 / HRESP=1 in cycle c; HRESET is high in cycle rst_cyc;
  // start stays high up to and including cycle hold_until.
  task automatic run_cmd(input logic [31:0] base, input logic [15:0] n,
                         input logic [31:0] fill, input logic inc,
                         input logic [63:0] wait_mask, input logic [63:0] resp_mask,
                         input int rst_cyc, input int hold_until, input int ncyc);
    logic        dph;
    logic [31:0] pend;
    base_addr = base; word_count = n; fill_data = fill; data_inc = inc;
    start = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK); #1;
    // Scramble command inputs: the DUT must use its latched copies.
    base_addr = 32'hDEAD_BEEC; word_count = 16'd7; fill_data = 32'h1234; data_inc = 1'b1;
    wr_addr.delete(); wr_data.delete();
    done_cycle = -1; done_count = 0; busy_cycles = 0; nonseq_cycles = 0;
    dph = 1'b0; pend = 32'd0;
    for (int c = 1; c < ncyc; c++) begin
      start = (c <= hold_until);
      obs_trans[c] = HTRANS; obs_addr[c] = HADDR; obs_data[c] = HWDATA;
      obs_busy[c] = busy; obs_err[c] = err; obs_hwrite[c] = HWRITE;
      if (done) begin
        if (done_cycle < 0) done_cycle = c;
        done_count++;
      end
      if (busy) busy_cycles++;
      if (HTRANS == 2'b10) nonseq_cycles++;
      HREADY = !wait_mask[c];
      HRESP  = resp_mask[c];
      HRESET = (c == rst_cyc);
      if (dph && HREADY) begin
        wr_addr.push_back(pend);
        wr_data.push_back(HWDATA);
        dph = 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        dph = 1'b1;
        pend = HADDR;
      end
      if (c == rst_cyc) dph = 1'b0;
      @(posedge HCLK); #1;
    end
    start = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRESET = 1'b0;
    $display("cmd base=0x%08h n=%0d fill=0x%08h inc=%0d done_cycle=%0d writes=%0d",
             base, n, fill, inc, done_cycle, wr_addr.size());
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] base,
                              input logic [31:0] fill, input logic inc);
    logic [31:0] ea, ed;
    check({tag, "_nwr"}, 64'(wr_addr.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wr_addr.size()) begin
        ea = base + 32'(4 * i);
        ed = fill + (inc ? 32'(i) : 32'd0);
        check($sformatf("%s_addr%0d", tag, i), wr_addr[i], ea);
        check($sformatf("%s_data%0d", tag, i), wr_data[i], ed);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("const_hsize", HSIZE, 3'b010);
    check("const_hburst", HBURST, 3'b000);
    check("const_hprot", HPROT, 4'b0011);
    check("const_hmastlock", HMASTLOCK, 1'b0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Zero-wait, constant data; start held through the DONE cycle.
    run_cmd(32'h2000_0000, 16'd4, 32'hA5A5_A5A5, 1'b0, 64'h0, 64'h0, 0, 6, 10);
    check("t1_done_cycle", 64'(done_cycle), 64'd6);
    check("t1_done_count", 64'(done_count), 64'd1);
    check("t1_busy_cycles", 64'(busy_cycles), 64'd5);
    check("t1_hwrite_c1", obs_hwrite[1], 1'b1);
    check("t1_htrans_c5", obs_trans[5], 2'b00);
    check("t1_hwrite_c5", obs_hwrite[5], 1'b0);
    check("t1_err", obs_err[9], 1'b0);
    check_writes("t1", 4, 32'h2000_0000, 32'hA5A5_A5A5, 1'b0);

    // Incrementing data, two wait states in cycles 3 and 4.
    run_cmd(32'h2000_0010, 16'd3, 32'h0000_00FF, 1'b1, 64'h18, 64'h0, 0, 0, 10);
    check("t2_done_cycle", 64'(done_cycle), 64'd7);
    check("t2_haddr_c3", obs_addr[3], 32'h2000_0018);
    check("t2_haddr_c4", obs_addr[4], 32'h2000_0018);
    check("t2_haddr_c5", obs_addr[5], 32'h2000_0018);
    check("t2_htrans_c4", obs_trans[4], 2'b10);
    check("t2_hwdata_c3", obs_data[3], 32'h0000_0100);
    check("t2_hwdata_c4", obs_data[4], 32'h0000_0100);
    check("t2_hwdata_c5", obs_data[5], 32'h0000_0100);
    check_writes("t2", 3, 32'h2000_0010, 32'h0000_00FF, 1'b1);

    // Address wrap at the top of the map.
    run_cmd(32'hFFFF_FFF8, 16'd3, 32'h0000_0005, 1'b0, 64'h0, 64'h0, 0, 0, 8);
    check("t3_done_cycle", 64'(done_cycle), 64'd5);
    check("t3_addr2", (wr_addr.size() > 2) ? wr_addr[2] : 32'hFFFF_FFFF, 32'h0000_0000);
    check_writes("t3", 3, 32'hFFFF_FFF8, 32'h0000_0005, 1'b0);

    // Unaligned base: low two bits dropped.
    run_cmd(32'h0000_1003, 16'd1, 32'h00C0_FFEE, 1'b1, 64'h0, 64'h0, 0, 0, 6);
    check("t3b_haddr_c1", obs_addr[1], 32'h0000_1000);
    check("t3b_done_cycle", 64'(done_cycle), 64'd3);
    check_writes("t3b", 1, 32'h0000_1000, 32'h00C0_FFEE, 1'b1);

    // Zero-length command.
    run_cmd(32'h2000_0000, 16'd0, 32'h1111_1111, 1'b0, 64'h0, 64'h0, 0, 0, 6);
    check("t4_done_cycle", 64'(done_cycle), 64'd1);
    check("t4_done_count", 64'(done_count), 64'd1);
    check("t4_busy_cycles", 64'(busy_cycles), 64'd0);
    check("t4_nonseq_cycles", 64'(nonseq_cycles), 64'd0);

    // Two-cycle ERROR response on beat 1 (cycles 3-4).
    run_cmd(32'h3000_0000, 16'd4, 32'h0000_0010, 1'b1, 64'h8, 64'h18, 0, 0, 12);
    check("t5_err_c2", obs_err[2], 1'b0);
    check("t5_htrans_c3", obs_trans[3], 2'b10);
    check("t5_htrans_c4", obs_trans[4], 2'b00);
    check("t5_haddr_c5", obs_addr[5], 32'h3000_0008);
    check("t5_htrans_c5", obs_trans[5], 2'b10);
    check("t5_done_cycle", 64'(done_cycle), 64'd8);
    check("t5_err_after", obs_err[11], 1'b1);
    check_writes("t5", 4, 32'h3000_0000, 32'h0000_0010, 1'b1);

    // Next command clears err.
    run_cmd(32'h3000_0100, 16'd1, 32'h0000_0009, 1'b0, 64'h0, 64'h0, 0, 0, 6);
    check("t5b_err_c1", obs_err[1], 1'b0);
    check("t5b_done_cycle", 64'(done_cycle), 64'd3);
    check_writes("t5b", 1, 32'h3000_0100, 32'h0000_0009, 1'b0);

    // Reset in cycle 3 of an 8-word command.
    run_cmd(32'h4000_0000, 16'd8, 32'hAAAA_0000, 1'b1, 64'h0, 64'h0, 3, 0, 14);
    check("t6_htrans_c3", obs_trans[3], 2'b10);
    check("t6_htrans_c4", obs_trans[4], 2'b00);
    check("t6_hwrite_c4", obs_hwrite[4], 1'b0);
    check("t6_haddr_c4", obs_addr[4], 32'd0);
    check("t6_hwdata_c4", obs_data[4], 32'd0);
    check("t6_busy_c4", obs_busy[4], 1'b0);
    check("t6_err_c4", obs_err[4], 1'b0);
    check("t6_done_count", 64'(done_count), 64'd0);
    check("t6_busy_cycles", 64'(busy_cycles), 64'd3);

    // Normal command after reset.
    run_cmd(32'h5000_0000, 16'd2, 32'h0000_0077, 1'b1, 64'h0, 64'h0, 0, 0, 8);
    check("t7_done_cycle", 64'(done_cycle), 64'd4);
    check("t7_busy_cycles", 64'(busy_cycles), 64'd3);
    check_writes("t7", 2, 32'h5000_0000, 32'h0000_0077, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
